// File: rtl/out_mem_ctrl.sv
// Round-robin write arbiter for two processing lanes feeding the output image memory.
// Zero-cycle combinational grant in RUN; registered write one cycle after transfer; lanes stall via gnt.
module out_mem_ctrl #(
  parameter int NUM_PIX = 76800,
  parameter int ADDR_W  = 17,
  parameter bit SAT     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req0,
  input  logic              req1,
  input  logic [31:0]       data0,
  input  logic [31:0]       data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] pix_count,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  state_t      state;
  logic        prio;
  logic        xfer;
  logic        last;
  logic [31:0] sel;
  logic        over;
  logic [7:0]  pix;

  // prio names the lane that wins when both request
  always_comb begin
    gnt0 = (state == RUN) && req0 && (!req1 || !prio);
    gnt1 = (state == RUN) && req1 && (!req0 ||  prio);
  end

  always_comb begin
    xfer = gnt0 || gnt1;
    last = (pix_count == LAST_ADDR);
    sel  = gnt1 ? data1 : data0;
    over = |sel[31:8];
    pix  = (SAT && over) ? 8'hFF : sel[7:0];
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      pix_count  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      frame_done <= 1'b0;
    end else begin
      mem_we     <= xfer;
      frame_done <= xfer && last;
      if (xfer) begin
        mem_addr  <= pix_count;
        mem_wdata <= pix;
        prio      <= gnt0;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            pix_count <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            pix_count <= pix_count + ADDR_W'(1);
            if (last) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_mem_ctrl.sv
// Scoreboard bench for out_mem_ctrl: a frame-level model predicts grants and writes for a SAT=1 and SAT=0 instance.
module tb_out_mem_ctrl;
  localparam int NP = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;

  logic gnt0, gnt1, mem_we, busy, frame_done;
  logic [AW-1:0] mem_addr, pix_count;
  logic [7:0] mem_wdata;
  logic t_gnt0, t_gnt1, t_we, t_busy, t_done;
  logic [AW-1:0] t_addr, t_cnt;
  logic [7:0] t_wdata;

  out_mem_ctrl #(.NUM_PIX(NP), .ADDR_W(AW), .SAT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pix_count(pix_count), .busy(busy), .frame_done(frame_done));

  out_mem_ctrl #(.NUM_PIX(NP), .ADDR_W(AW), .SAT(1'b0)) dut_trunc (
    .clk(clk), .rst(rst), .start(start), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(t_gnt0), .gnt1(t_gnt1),
    .mem_we(t_we), .mem_addr(t_addr), .mem_wdata(t_wdata),
    .pix_count(t_cnt), .busy(t_busy), .frame_done(t_done));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int addr;
    int sat;
    int tr;
    int last;
  } exp_t;
  exp_t q[$];

  // frame model: running flag, lane that wins a tie, pixels taken so far
  bit m_run = 1'b0;
  int m_tie = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock of stimulus: inputs already applied; predict, compare, advance
  task automatic step(output bit got0, output bit got1);
    logic [31:0] d;
    bit w0, w1;
    @(negedge clk);
    w0 = 1'b0;
    w1 = 1'b0;
    if (m_run && !rst) begin
      if (req0 && req1) begin
        w0 = (m_tie == 0);
        w1 = (m_tie == 1);
      end else begin
        w0 = req0;
        w1 = req1;
      end
    end
    chk("gnt0", gnt0, w0);
    chk("gnt1", gnt1, w1);
    chk("gnt_trunc", {t_gnt1, t_gnt0}, {w1, w0});
    chk("busy", busy, m_run);
    chk("pix_count", pix_count, m_cnt);
    if (w0 || w1) begin
      d = w1 ? data1 : data0;
      q.push_back('{cyc + 1, m_cnt, (d > 32'd255) ? 255 : int'(d[7:0]), int'(d[7:0]),
                    (m_cnt == NP - 1) ? 1 : 0});
      m_cnt++;
      m_tie = w1 ? 0 : 1;
      if (m_cnt == NP) m_run = 1'b0;
    end else if (!m_run && start && !rst) begin
      m_run = 1'b1;
      m_cnt = 0;
    end
    got0 = w0;
    got1 = w1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit r0, input bit r1,
                       input logic [31:0] d0, input logic [31:0] d1, input int n);
    bit g0, g1;
    start = s; req0 = r0; req1 = r1; data0 = d0; data1 = d1;
    for (int i = 0; i < n; i++) step(g0, g1);
    start = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("missing_write", 32'd0, 32'd1);
        void'(q.pop_front());
      end
      if (mem_we) begin
        if (q.size() == 0) begin
          chk("spurious_write", mem_addr, 32'hFFFF);
        end else begin
          e = q.pop_front();
          chk("write_cycle", cyc, e.due);
          chk("mem_addr", mem_addr, e.addr);
          chk("wdata_sat", mem_wdata, e.sat);
          chk("wdata_trunc", t_wdata, e.tr);
          chk("addr_trunc", t_addr, e.addr);
          chk("frame_done", frame_done, e.last);
          chk("we_trunc", t_we, 1);
        end
      end else begin
        chk("done_without_we", frame_done, 0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    bit g0, g1;
    rst = 1'b1;
    #2;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_frame_done", frame_done, 0);
    drive(0, 0, 0, 0, 0, 2);
    rst = 1'b0;

    drive(0, 1, 1, 32'hA0, 32'hB1, 2);        // IDLE with requests: no grants
    drive(1, 1, 1, 32'hA0, 32'hB1, 1);        // enter RUN
    drive(0, 1, 1, 32'hA0, 32'hB1, 12);       // full frame then DONE with reqs high
    drive(1, 0, 0, 0, 0, 1);                  // restart
    drive(0, 1, 0, 32'h12, 0, 3);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);                  // start in RUN is ignored
    drive(0, 1, 0, 32'h1FF, 0, 1);
    drive(0, 1, 0, 32'h100, 0, 1);            // pix_count reaches 5, lane 0 last
    chk("we_before_rst", mem_we, 1);

    rst = 1'b1;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_frame_done", frame_done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_gnt", {gnt1, gnt0}, 0);
    chk("arst_pix_count", pix_count, 0);
    q.delete();
    m_run = 1'b0; m_tie = 0; m_cnt = 0;
    req0 = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    drive(1, 1, 1, 32'h33, 32'h44, 1);
    drive(0, 1, 1, 32'h33, 32'h44, 3);

    // random traffic: requests held with their data until granted
    g0 = 1'b1; g1 = 1'b1;
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 15) == 0);
      if (!req0 || g0) begin
        req0 = $urandom_range(0, 2) != 0;
        data0 = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300);
      end
      if (!req1 || g1) begin
        req1 = $urandom_range(0, 2) != 0;
        data1 = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300);
      end
      step(g0, g1);
    end
    drive(0, 0, 0, 0, 0, 3);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/out_mem_ctrl.md
# out_mem_ctrl

Write controller and arbiter for the output image memory (320x240 = 76800 8-bit pixels). It accepts 32-bit results from two processing lanes over a req/gnt handshake and arbitrates them round-robin. Each granted result is reduced to an 8-bit pixel and written at a sequential pixel address. It tracks frame progress and raises a one-cycle `frame_done` after the last pixel, then blocks further writes until the next `start`.

## Interface
- `NUM_PIX`, 76800, pixels per frame
- `ADDR_W`, 17, pixel address width; must satisfy 2^ADDR_W >= NUM_PIX
- `SAT`, 1, 1 = clamp results above 255 to 255; 0 = truncate to `data[7:0]`

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a frame; honoured only in IDLE or DONE
- `req0`, `req1`  in  1  lane result valid; held with data until granted
- `data0`, `data1`  in  32  lane result, unsigned
- `gnt0`, `gnt1`  out  1  combinational grant; transfer = req & gnt at rising edge
- `mem_we`  out  1  registered memory write strobe
- `mem_addr`  out  ADDR_W  registered pixel address
- `mem_wdata`  out  8  registered pixel value
- `pix_count`  out  ADDR_W  pixels accepted in the current frame
- `busy`  out  1  high in RUN
- `frame_done`  out  1  one-cycle pulse, coincident with the last pixel's `mem_we`

## Operation
- States:
  - IDLE: reset state; no grants.
  - RUN: grants issued.
  - DONE: frame complete; no grants.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --transfer while `pix_count == NUM_PIX-1`--> DONE.
  - DONE --start--> RUN.
  - `start` in RUN is ignored.
- Entering RUN (from IDLE or DONE): `pix_count` cleared to 0 on the same edge.
- Arbitration (RUN only):
  - Round-robin pointer `prio`, reset 0.
  - Only one requester active: it is granted.
  - Both active: `gnt[prio]` is granted.
  - After any transfer from lane i, `prio` = 1-i.
  - `prio` is unchanged on cycles without a transfer.
  - At most one grant per cycle; `gnt0 & gnt1` is never 1.
  - Grants are 0 outside RUN even if req is high.
- Pixel conversion:
  - SAT=1: `mem_wdata` = (data > 255) ? 255 : data[7:0].
  - SAT=0: `mem_wdata` = data[7:0].
- Addressing:
  - `mem_addr` = `pix_count` value at transfer time.
  - `pix_count` increments by 1 per transfer; no wrap, since RUN exits at NUM_PIX-1.
  - `pix_count` holds NUM_PIX in DONE until the next `start`.
- `busy` = (state == RUN), registered with the state.
- Reset (any time, including mid-frame):
  - state IDLE; `prio` 0; `pix_count` 0.
  - `mem_we`, `mem_addr`, `mem_wdata`, `frame_done` all 0.
  - `busy`, `gnt0`, `gnt1` 0.
  - Partially written frame is abandoned; the next `start` restarts at address 0.

## Timing
- Grant is combinational from state, `prio`, `req0/1`; zero-cycle grant in RUN.
- Write latency: `mem_we`/`mem_addr`/`mem_wdata` valid the cycle after the transfer edge, for exactly one cycle.
- `mem_we` is 0 on cycles following a non-transfer edge.
- Throughput: one pixel per cycle sustained; both lanes requesting continuously alternate 0,1,0,1...
- Last pixel:
  - The transfer edge moves state to DONE.
  - The next cycle shows `mem_we`=1, `mem_addr`=NUM_PIX-1, `frame_done`=1, `busy`=0.
  - `gnt` is 0 from that cycle on.
- `start` and the last transfer on the same edge: `start` is ignored (state was RUN).
- A `start` one cycle later in DONE re-enters RUN.

## Test plan
- Reset, `start`, `req0`=1 with `data0`=0x12 for 3 cycles -> writes 0x12 at addr 0,1,2 on consecutive cycles; `pix_count`=3; `gnt1` never 1.
- Both reqs held high, `data0`=0xA0, `data1`=0xB1 -> grants alternate 0,1,0,1 starting with lane 0; `mem_wdata` sequence A0,B1,A0,B1 at addr 0..3.
- SAT=1: data 0x0000_01FF -> `mem_wdata`=0xFF. SAT=0: same data -> 0xFF. Data 0x100 gives 0xFF (SAT=1) and 0x00 (SAT=0).
- NUM_PIX=8 build, continuous req:
  - 8 writes at addr 0..7; `frame_done` pulses with addr 7; then `busy`=0 and gnt=0 despite req.
  - A new `start` -> addr restarts at 0.
- `rst` asserted mid-frame at `pix_count`=5, `mem_we` high -> all outputs 0 immediately (async, before next edge); after release and `start`, the first write goes to addr 0 with `prio`=0.
- req high while IDLE, and `start` pulsed in RUN -> no grants in IDLE; the RUN `start` does not clear `pix_count`.
